// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : boot-time byte-stream to instruction-memory writer; holds the
//               core until a header-counted, big-endian word image is written.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_run,
   output logic              load_done,
   output logic              load_err
);

   localparam int          c_WC_W  = ADDR_W + 1;
   localparam logic [31:0] c_DEPTH = 32'(DEPTH);

   typedef enum logic [1:0] {
      S_HDR  = 2'd0,
      S_DATA = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t              r_state;
   logic [1:0]          r_byte_cnt;
   logic [c_WC_W-1:0]   r_word_cnt;
   logic [31:0]         r_count;
   logic [23:0]         r_word;

   logic                w_xfer;
   logic [31:0]         w_count_next;
   logic [31:0]         w_word_next;
   logic [c_WC_W-1:0]   w_word_inc;

   assign w_xfer       = byte_valid && byte_ready;
   assign w_count_next = {r_count[23:0], byte_data};
   assign w_word_next  = {r_word, byte_data};
   assign w_word_inc   = r_word_cnt + c_WC_W'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_HDR;
         r_byte_cnt <= 2'd0;
         r_word_cnt <= '0;
         r_count    <= 32'd0;
         r_word     <= 24'd0;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         core_run   <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         // restart outranks any byte offered in the same cycle
         if (restart) begin
            r_state    <= S_HDR;
            r_byte_cnt <= 2'd0;
            r_word_cnt <= '0;
            r_count    <= 32'd0;
            r_word     <= 24'd0;
            byte_ready <= 1'b1;
            core_run   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
         end else begin
            case (r_state)
               S_HDR: begin
                  byte_ready <= 1'b1;
                  if (w_xfer) begin
                     r_count    <= w_count_next;
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                     if (r_byte_cnt == 2'd3) begin
                        if (w_count_next == 32'd0) begin
                           r_state    <= S_DONE;
                           byte_ready <= 1'b0;
                           core_run   <= 1'b1;
                           load_done  <= 1'b1;
                        end else if (w_count_next > c_DEPTH) begin
                           r_state    <= S_ERR;
                           byte_ready <= 1'b0;
                           load_err   <= 1'b1;
                        end else begin
                           r_state <= S_DATA;
                        end
                     end
                  end
               end
               S_DATA: begin
                  byte_ready <= 1'b1;
                  if (w_xfer) begin
                     r_word     <= w_word_next[23:0];
                     r_byte_cnt <= r_byte_cnt + 2'd1;
                     if (r_byte_cnt == 2'd3) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= r_word_cnt[ADDR_W-1:0];
                        imem_wdata <= w_word_next;
                        r_word_cnt <= w_word_inc;
                        // core release waits one cycle in DONE so it follows the final write
                        if (32'(w_word_inc) == r_count) begin
                           r_state    <= S_DONE;
                           byte_ready <= 1'b0;
                        end
                     end
                  end
               end
               S_DONE: begin
                  byte_ready <= 1'b0;
                  core_run   <= 1'b1;
                  load_done  <= 1'b1;
               end
               S_ERR: begin
                  byte_ready <= 1'b0;
                  core_run   <= 1'b0;
                  load_err   <= 1'b1;
               end
               default: r_state <= S_HDR;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : randomized scoreboard bench for imem_loader.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;

   logic              clk;
   logic              rstn;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              restart;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_run;
   logic              load_done;
   logic              load_err;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .restart    (restart),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_run   (core_run),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t exp_q[$];
   int  wr_cyc_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every write strobe is matched against the scoreboard head.
   always @(negedge clk) begin
      if (rstn && imem_we) begin
         wr_t e;
         wr_cyc_q.push_back(cyc);
         check("core_held_during_write", {31'd0, core_run}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h expected none", imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(imem_addr), 32'(e.addr));
            check("write_data", imem_wdata, e.data);
         end
      end
   end

   task automatic idle(input int n);
      byte_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Offer a byte at a falling edge; it transfers on the next rising edge where ready is seen.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!byte_ready) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout: got ready 0 expected 1 within 50 cycles");
         byte_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int b = 0; b < 4; b++) begin
         logic [31:0] tmp;
         tmp = w << (8 * b);
         send_byte(tmp[31:24]);
         if (gaps && b != 3 && ($urandom % 3) == 0) idle(1 + ($urandom % 2));
      end
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(posedge clk);
      @(negedge clk);
      restart = 1'b0;
      exp_q.delete();
   endtask

   // Full load of n random words (n >= 1) checked through the scoreboard and release timing.
   task automatic do_load(input int n, input bit gaps);
      logic [31:0] w;
      send_word(32'(n), gaps);
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         for (int b = 0; b < 4; b++) begin
            logic [31:0] tmp;
            tmp = w << (8 * b);
            if (b == 3) exp_q.push_back('{addr: ADDR_W'(i), data: w});
            send_byte(tmp[31:24]);
            if (gaps && !(b == 3 && i == n - 1) && ($urandom % 3) == 0) idle(1 + ($urandom % 2));
         end
      end
      byte_valid = 1'b0;
      check("last_write_strobe", {31'd0, imem_we}, 32'd1);
      check("core_held_at_last_write", {31'd0, core_run}, 32'd0);
      @(negedge clk);
      check("core_run_after_load", {31'd0, core_run}, 32'd1);
      check("load_done_after_load", {31'd0, load_done}, 32'd1);
      check("ready_low_in_done", {31'd0, byte_ready}, 32'd0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rstn       = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      restart    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, byte_ready}, 32'd0);
      check("rst_core_run", {31'd0, core_run}, 32'd0);
      check("rst_load_err", {31'd0, load_err}, 32'd0);
      rstn = 1'b1;
      check("ready_still_low_at_release", {31'd0, byte_ready}, 32'd0);
      @(negedge clk);
      check("ready_after_release", {31'd0, byte_ready}, 32'd1);

      // Directed two-word image.
      send_word(32'd2, 1'b0);
      exp_q.push_back('{addr: 10'd0, data: 32'h3C021234});
      send_word(32'h3C021234, 1'b0);
      exp_q.push_back('{addr: 10'd1, data: 32'h08000005});
      send_word(32'h08000005, 1'b0);
      byte_valid = 1'b0;
      check("t1_core_held", {31'd0, core_run}, 32'd0);
      @(negedge clk);
      check("t1_core_run", {31'd0, core_run}, 32'd1);
      check("t1_load_done", {31'd0, load_done}, 32'd1);
      repeat (3) @(negedge clk);
      check("t1_done_holds", {31'd0, core_run}, 32'd1);

      // Empty image.
      pulse_restart();
      check("restart_clears_run", {31'd0, core_run}, 32'd0);
      send_word(32'd0, 1'b0);
      byte_valid = 1'b0;
      check("t2_core_run", {31'd0, core_run}, 32'd1);
      check("t2_load_done", {31'd0, load_done}, 32'd1);
      check("t2_ready_low", {31'd0, byte_ready}, 32'd0);

      // Oversized header.
      pulse_restart();
      send_word(32'h00000401, 1'b0);
      byte_valid = 1'b0;
      check("t3_load_err", {31'd0, load_err}, 32'd1);
      check("t3_ready_low", {31'd0, byte_ready}, 32'd0);
      check("t3_core_held", {31'd0, core_run}, 32'd0);
      repeat (2) @(negedge clk);
      check("t3_err_sticky", {31'd0, load_err}, 32'd1);
      pulse_restart();
      check("t3_err_cleared", {31'd0, load_err}, 32'd0);
      check("t3_ready_back", {31'd0, byte_ready}, 32'd1);

      // Exactly DEPTH is legal: enters DATA, keeps accepting.
      send_word(32'd1024, 1'b0);
      byte_valid = 1'b0;
      check("depth_not_err", {31'd0, load_err}, 32'd0);
      check("depth_ready", {31'd0, byte_ready}, 32'd1);

      // Back-to-back stream: writes exactly 4 cycles apart.
      pulse_restart();
      wr_cyc_q.delete();
      do_load(3, 1'b0);
      check("t4_write_count", 32'(wr_cyc_q.size()), 32'd3);
      if (wr_cyc_q.size() == 3) begin
         check("t4_spacing_01", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd4);
         check("t4_spacing_12", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 32'd4);
      end

      // Restart with a colliding byte mid-word: byte dropped, no write, fresh header next.
      pulse_restart();
      send_word(32'd2, 1'b0);
      send_byte(8'hAA);
      send_byte(8'hBB);
      restart    = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h00;
      @(posedge clk);
      @(negedge clk);
      restart    = 1'b0;
      byte_valid = 1'b0;
      check("t5_run_low", {31'd0, core_run}, 32'd0);
      send_word(32'd1, 1'b0);
      exp_q.push_back('{addr: 10'd0, data: 32'hCAFEF00D});
      send_word(32'hCAFEF00D, 1'b0);
      byte_valid = 1'b0;
      @(negedge clk);
      check("t5_core_run", {31'd0, core_run}, 32'd1);

      // Asynchronous reset between edges mid-DATA.
      pulse_restart();
      send_word(32'd3, 1'b0);
      exp_q.push_back('{addr: 10'd0, data: 32'h12345678});
      send_word(32'h12345678, 1'b0);
      send_byte(8'h9A);
      byte_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check("t6_ready", {31'd0, byte_ready}, 32'd0);
      check("t6_we", {31'd0, imem_we}, 32'd0);
      check("t6_addr", 32'(imem_addr), 32'd0);
      check("t6_wdata", imem_wdata, 32'd0);
      check("t6_run_done_err", {29'd0, core_run, load_done, load_err}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      do_load(2, 1'b1);

      // Randomized loads with random gaps.
      for (int k = 0; k < 8; k++) begin
         pulse_restart();
         do_load(1 + int'($urandom % 6), 1'b1);
      end

      repeat (3) @(negedge clk);
      check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
